alu_result_stage: RTL and testbench

//  Registered output stage downstream of the bitwise/arith units (or_all, and_all, adder).
//  - Selects one 32-bit result by opcode and generates flags.
//  - Buffers the result in a 2-entry skid buffer under valid/ready.
//  - Keeps a sticky overflow flag.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_skid_buf.sv | 66 ++++++
 rtl/alu_result_stage.sv | 90 +++++++++
 tb/tb_alu_result_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU result-stage definitions: opcode encodings, flag layout and bit positions.
package alu_pkg;

   localparam int FLAGS_W = 4;

   typedef logic [1:0] op_t;

   localparam op_t OP_AND = 2'b00;
   localparam op_t OP_OR  = 2'b01;
   localparam op_t OP_ADD = 2'b10;
   localparam op_t OP_SLT = 2'b11;

   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry skid buffer: main reg drives the output, skid reg absorbs one bundle under stall.
// One cycle in to out; in_rdy is a flop (!skid full), so there is no combinational path from out_rdy.
module alu_skid_buf #(
   parameter int DW = 36
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_vld,
   output logic          in_rdy,
   input  logic [DW-1:0] in_dat,
   output logic          out_vld,
   input  logic          out_rdy,
   output logic [DW-1:0] out_dat
);

   logic          m_vld_q, m_vld_d;
   logic          s_vld_q, s_vld_d;
   logic [DW-1:0] m_dat_q, m_dat_d;
   logic [DW-1:0] s_dat_q, s_dat_d;
   logic          accept;
   logic          deliver;

   assign in_rdy  = !s_vld_q;
   assign out_vld = m_vld_q;
   assign out_dat = m_dat_q;
   assign accept  = in_vld && !s_vld_q;
   assign deliver = m_vld_q && out_rdy;

   always_comb begin
      m_vld_d = m_vld_q;
      m_dat_d = m_dat_q;
      s_vld_d = s_vld_q;
      s_dat_d = s_dat_q;
      if (!m_vld_q || deliver) begin
         // Skid entry is older than anything arriving now, so it goes first.
         if (s_vld_q) begin
            m_vld_d = 1'b1;
            m_dat_d = s_dat_q;
            s_vld_d = 1'b0;
         end else if (accept) begin
            m_vld_d = 1'b1;
            m_dat_d = in_dat;
         end else begin
            m_vld_d = 1'b0;
         end
      end else if (accept) begin
         s_vld_d = 1'b1;
         s_dat_d = in_dat;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_vld_q <= 1'b0;
         s_vld_q <= 1'b0;
         m_dat_q <= '0;
         s_dat_q <= '0;
      end else begin
         m_vld_q <= m_vld_d;
         s_vld_q <= s_vld_d;
         m_dat_q <= m_dat_d;
         s_dat_q <= s_dat_d;
      end
   end

endmodule

// File: rtl/alu_result_stage.sv
// Selects the ALU result by opcode, derives {Z,N,C,V}, and registers it through a 2-entry skid buffer.
// One cycle accept to out_valid; in_ready drops only when the skid entry is occupied.
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         in_op,
   input  logic [W-1:0]       in_and,
   input  logic [W-1:0]       in_or,
   input  logic [W-1:0]       in_sum,
   input  logic               in_cout,
   input  logic               in_ovf,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [W-1:0]       out_y,
   output logic [FLAGS_W-1:0] out_flags,
   output logic               ovf_sticky,
   input  logic               ovf_clr
);

   logic [W-1:0]         res_y;
   logic [FLAGS_W-1:0]   res_flags;
   logic [W+FLAGS_W-1:0] buf_out;
   logic                 accept;
   logic                 ovf_sticky_q, ovf_sticky_d;

   always_comb begin
      res_y = in_sum;
      unique case (in_op)
         OP_AND:  res_y = in_and;
         OP_OR:   res_y = in_or;
         OP_ADD:  res_y = in_sum;
         // Signed a<b from a-b: sign of the true difference is sum MSB corrected by overflow.
         OP_SLT:  res_y = {{(W-1){1'b0}}, in_sum[W-1] ^ in_ovf};
         default: res_y = in_sum;
      endcase
   end

   always_comb begin
      res_flags         = '0;
      res_flags[FLAG_Z] = (res_y == '0);
      res_flags[FLAG_N] = res_y[W-1];
      res_flags[FLAG_C] = (in_op == OP_ADD) && in_cout;
      res_flags[FLAG_V] = (in_op == OP_ADD) && in_ovf;
   end

   assign accept = in_valid && in_ready;

   alu_skid_buf #(
      .DW(W + FLAGS_W)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (in_valid),
      .in_rdy  (in_ready),
      .in_dat  ({res_y, res_flags}),
      .out_vld (out_valid),
      .out_rdy (out_ready),
      .out_dat (buf_out)
   );

   assign out_y     = buf_out[W+FLAGS_W-1:FLAGS_W];
   assign out_flags = buf_out[FLAGS_W-1:0];

   // A new overflow in the same cycle as a clear must not be lost.
   always_comb begin
      ovf_sticky_d = ovf_sticky_q;
      if (accept && res_flags[FLAG_V]) begin
         ovf_sticky_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_sticky_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_sticky_q <= 1'b0;
      end else begin
         ovf_sticky_q <= ovf_sticky_d;
      end
   end

   assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed vector table, hand-written stall/sticky/reset sequences,
// and a random valid/ready stream against a queue-based reference model.
module tb_alu_result_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [31:0] in_and;
   logic [31:0] in_or;
   logic [31:0] in_sum;
   logic        in_cout;
   logic        in_ovf;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_y;
   logic [3:0]  out_flags;
   logic        ovf_sticky;
   logic        ovf_clr;

   int n_vec = 0;
   int n_bad = 0;

   alu_result_stage #(.W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_and     (in_and),
      .in_or      (in_or),
      .in_sum     (in_sum),
      .in_cout    (in_cout),
      .in_ovf     (in_ovf),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_y      (out_y),
      .out_flags  (out_flags),
      .ovf_sticky (ovf_sticky),
      .ovf_clr    (ovf_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a_and;
      logic [31:0] a_or;
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      logic [31:0] y;
      logic [3:0]  fl;
   } vec_t;

   vec_t vt[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic put(input logic [1:0] op, input logic [31:0] a_and, input logic [31:0] a_or,
                      input logic [31:0] sum, input logic cout, input logic ovf);
      in_valid = 1'b1;
      in_op    = op;
      in_and   = a_and;
      in_or    = a_or;
      in_sum   = sum;
      in_cout  = cout;
      in_ovf   = ovf;
   endtask

   // Reference model state for the random stream
   logic [35:0] mq[$];
   logic        sticky_m;
   logic [31:0] a, b, ey;
   logic [32:0] t;
   logic        sub, ec, ev;
   logic [3:0]  ef;
   longint      r;
   int          accepted, cyc;
   logic        exp_acc, exp_del;

   initial begin
      vt[0] = '{2'b01, 32'h1234_5678, 32'hF0F0_0000, 32'h0000_0001, 1'b1, 1'b1, 32'hF0F0_0000, 4'b0100};
      vt[1] = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 4'b1010};
      vt[2] = '{2'b11, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0001, 4'b0000};
      vt[3] = '{2'b00, 32'h0000_0000, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b1, 32'h0000_0000, 4'b1000};
      vt[4] = '{2'b11, 32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b1, 32'h0000_0000, 4'b1000};
      vt[5] = '{2'b10, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b0101};
      vt[6] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0001, 4'b0000};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
      in_op = 2'b00; in_and = '0; in_or = '0; in_sum = '0; in_cout = 1'b0; in_ovf = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_y", out_y, 0);
      chk("rst_out_flags", out_flags, 0);
      chk("rst_sticky", ovf_sticky, 0);
      chk("rst_in_ready", in_ready, 1);

      // Back-to-back table stream at full throughput
      out_ready = 1'b1;
      for (int i = 0; i <= 7; i++) begin
         @(negedge clk);
         if (i > 0) begin
            chk($sformatf("tbl%0d_valid", i-1), out_valid, 1);
            chk($sformatf("tbl%0d_y", i-1), out_y, vt[i-1].y);
            chk($sformatf("tbl%0d_flags", i-1), out_flags, vt[i-1].fl);
            chk($sformatf("tbl%0d_in_ready", i-1), in_ready, 1);
         end
         if (i < 7) put(vt[i].op, vt[i].a_and, vt[i].a_or, vt[i].sum, vt[i].cout, vt[i].ovf);
         else in_valid = 1'b0;
      end

      // Sticky overflow: set by table entry 5, clear, set, set-vs-clear, clear
      chk("stk_after_tbl", ovf_sticky, 1);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk("stk_cleared", ovf_sticky, 0);
      put(2'b10, 0, 0, 32'h8000_0000, 1'b0, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("stk_set", ovf_sticky, 1);
      put(2'b10, 0, 0, 32'h7FFF_FFFF, 1'b1, 1'b1);
      ovf_clr = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("stk_set_wins", ovf_sticky, 1);
      @(negedge clk);
      ovf_clr = 1'b0;
      chk("stk_clr_alone", ovf_sticky, 0);
      @(negedge clk);
      chk("drain_valid", out_valid, 0);

      // Backpressure: two accepts while stalled fill both entries
      out_ready = 1'b0;
      put(2'b00, 32'h1, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      chk("bp_first_valid", out_valid, 1);
      chk("bp_first_y", out_y, 32'h1);
      chk("bp_first_in_ready", in_ready, 1);
      put(2'b01, 32'hCAFE_0000, 32'h2, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_full_in_ready", in_ready, 0);
      chk("bp_hold_y", out_y, 32'h1);
      @(negedge clk);
      chk("bp_hold2_y", out_y, 32'h1);
      chk("bp_hold2_flags", out_flags, 4'b0000);
      chk("bp_hold2_in_ready", in_ready, 0);
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_second_y", out_y, 32'h2);
      chk("bp_second_valid", out_valid, 1);
      chk("bp_in_ready_back", in_ready, 1);
      @(negedge clk);
      chk("bp_empty", out_valid, 0);

      // Reset while both entries are full
      out_ready = 1'b0;
      put(2'b10, 0, 0, 32'h5, 1'b0, 1'b1);
      @(negedge clk);
      put(2'b01, 0, 32'h6, 0, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("rm_full", in_ready, 0);
      chk("rm_sticky_pre", ovf_sticky, 1);
      rst = 1'b1;
      #1;
      chk("rm_out_valid", out_valid, 0);
      chk("rm_in_ready", in_ready, 1);
      chk("rm_out_y", out_y, 0);
      chk("rm_sticky", ovf_sticky, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rm_post_valid", out_valid, 0);
      chk("rm_post_in_ready", in_ready, 1);

      // Random stream against the queue model
      sticky_m = 1'b0;
      accepted = 0;
      cyc = 0;
      while (accepted < 1000 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         chk("rnd_valid", out_valid, (mq.size() > 0) ? 1 : 0);
         chk("rnd_in_ready", in_ready, (mq.size() < 2) ? 1 : 0);
         chk("rnd_sticky", ovf_sticky, sticky_m);
         if (mq.size() > 0) begin
            chk("rnd_y", out_y, mq[0][35:4]);
            chk("rnd_flags", out_flags, mq[0][3:0]);
         end

         a = $urandom;
         b = ($urandom_range(0, 7) == 0) ? a : $urandom;
         in_op = 2'($urandom_range(0, 3));
         sub = (in_op == 2'b11) ? 1'b1 : 1'($urandom_range(0, 1));
         if (sub) begin
            in_sum = a - b;
            t = {1'b0, a} + {1'b0, ~b} + 33'd1;
            r = longint'($signed(a)) - longint'($signed(b));
         end else begin
            in_sum = a + b;
            t = {1'b0, a} + {1'b0, b};
            r = longint'($signed(a)) + longint'($signed(b));
         end
         in_cout = t[32];
         in_ovf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
         in_and  = a & b;
         in_or   = a | b;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         ovf_clr   = ($urandom_range(0, 15) == 0);

         case (in_op)
            2'b00:   ey = a & b;
            2'b01:   ey = a | b;
            2'b10:   ey = in_sum;
            default: ey = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         endcase
         ec = (in_op == 2'b10) ? in_cout : 1'b0;
         ev = (in_op == 2'b10) ? in_ovf : 1'b0;
         ef = {ey == 32'd0, ey[31], ec, ev};

         exp_acc = in_valid && (mq.size() < 2);
         exp_del = out_ready && (mq.size() > 0);
         if (exp_del) void'(mq.pop_front());
         if (exp_acc) begin
            mq.push_back({ey, ef});
            accepted++;
         end
         if (exp_acc && ev) sticky_m = 1'b1;
         else if (ovf_clr) sticky_m = 1'b0;
      end
      if (accepted < 1000) begin
         n_vec++;
         n_bad++;
         $display("FAIL rnd_timeout: accepted %0d required 1000", accepted);
      end

      in_valid = 1'b0;
      ovf_clr = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rnd_drained", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
